mem_stream_fetcher: RTL and testbench

Multi-channel sequential memory fetcher between the sparse-matrix decoding pipelines and the shared tagged memory port (`req_mem_*` / `rsp_mem_*`). It is the parametrised successor of the decoder's single stream-load path. Each channel is armed with a base byte address and a word count. The block round-robins tagged 64-bit loads across active channels and steers responses by tag into per-channel FIFOs. Issue is credit-limited so a response is never dropped and `rsp_mem_stall` is never needed.

---
 rtl/mem_stream_fetcher.sv | 151 +++++++++++++++
 tb/tb_mem_stream_fetcher.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_fetcher.sv
// Multi-channel sequential memory fetcher. It issues round-robin, credit-limited
// tagged loads and steers tagged responses into per-channel FIFOs.
module mem_stream_fetcher #(
   parameter int CHANNELS = 4,
   parameter int TAG_W    = $clog2(CHANNELS),
   parameter int ADDR_W   = 48,
   parameter int DATA_W   = 64,
   parameter int DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [TAG_W-1:0]             start_ch,
   input  logic [ADDR_W-1:0]            start_addr,
   input  logic [31:0]                  start_len,
   output logic [CHANNELS-1:0]          busy,
   output logic                         err,
   output logic                         req_mem_ld,
   output logic [ADDR_W-1:0]            req_mem_addr,
   output logic [TAG_W-1:0]             req_mem_tag,
   input  logic                         req_mem_stall,
   input  logic                         rsp_mem_push,
   input  logic [TAG_W-1:0]             rsp_mem_tag,
   input  logic [DATA_W-1:0]            rsp_mem_q,
   output logic                         rsp_mem_stall,
   output logic [CHANNELS-1:0]          valid,
   output logic [CHANNELS*DATA_W-1:0]   q,
   input  logic [CHANNELS-1:0]          pop
);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int CRW = CW + 1;
   localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(DATA_W / 8);
   localparam logic [CRW-1:0]    CREDIT_MAX = CRW'(DEPTH);
   localparam logic [TAG_W-1:0]  LAST_CH    = TAG_W'(CHANNELS - 1);

   logic [ADDR_W-1:0] addr_r        [CHANNELS];
   logic [31:0]       remaining_r   [CHANNELS];
   logic [CW-1:0]     outstanding_r [CHANNELS];
   logic [CW-1:0]     count_r       [CHANNELS];
   logic [PW-1:0]     rd_ptr_r      [CHANNELS];
   logic [PW-1:0]     wr_ptr_r      [CHANNELS];
   logic [DATA_W-1:0] fifo_r        [CHANNELS][DEPTH];
   logic [TAG_W-1:0]  rr_r;
   logic              err_r;
   logic              req_ld_r;
   logic [ADDR_W-1:0] req_addr_r;
   logic [TAG_W-1:0]  req_tag_r;

   logic [CHANNELS-1:0] busy_s, eligible_s, hit_s, pop_ok_s, arm_s, rearm_s, issue_s;
   logic                grant_valid_s, issue_any_s, rsp_err_s;
   logic [TAG_W-1:0]    grant_s, scan_s, rr_next_s;

   // Per-channel status: busy, credit eligibility, response/pop/arm qualification, FIFO heads.
   always_comb begin
      busy_s     = {CHANNELS{1'b0}};
      eligible_s = {CHANNELS{1'b0}};
      hit_s      = {CHANNELS{1'b0}};
      pop_ok_s   = {CHANNELS{1'b0}};
      arm_s      = {CHANNELS{1'b0}};
      rearm_s    = {CHANNELS{1'b0}};
      valid      = {CHANNELS{1'b0}};
      q          = {(CHANNELS*DATA_W){1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
         busy_s[c]     = (remaining_r[c] != 32'd0) || (outstanding_r[c] != {CW{1'b0}});
         // credit counts both words in flight and words parked in the FIFO
         eligible_s[c] = (remaining_r[c] != 32'd0) &&
                         (({1'b0, outstanding_r[c]} + {1'b0, count_r[c]}) < CREDIT_MAX);
         hit_s[c]      = rsp_mem_push && (rsp_mem_tag == TAG_W'(c)) &&
                         (outstanding_r[c] != {CW{1'b0}});
         pop_ok_s[c]   = pop[c] && (count_r[c] != {CW{1'b0}});
         arm_s[c]      = start && (start_ch == TAG_W'(c)) && !busy_s[c];
         rearm_s[c]    = start && (start_ch == TAG_W'(c)) && busy_s[c];
         valid[c]      = (count_r[c] != {CW{1'b0}});
         q[c*DATA_W +: DATA_W] = valid[c] ? fifo_r[c][rd_ptr_r[c]] : {DATA_W{1'b0}};
      end
      rsp_err_s = rsp_mem_push && (hit_s == {CHANNELS{1'b0}});
   end

   // Round-robin arbiter: first eligible channel at or after rr.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_s       = {TAG_W{1'b0}};
      scan_s        = {TAG_W{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         scan_s        = TAG_W'((int'(rr_r) + i) % CHANNELS);
         grant_s       = (eligible_s[scan_s] && !grant_valid_s) ? scan_s : grant_s;
         grant_valid_s = grant_valid_s || eligible_s[scan_s];
      end
      issue_any_s = grant_valid_s && !req_mem_stall;
      issue_s     = {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
         issue_s[c] = issue_any_s && (grant_s == TAG_W'(c));
      end
      rr_next_s = (grant_s == LAST_CH) ? {TAG_W{1'b0}} : grant_s + TAG_W'(1);
   end

   // Channel counters, request register, arbitration pointer and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            addr_r[c]        <= {ADDR_W{1'b0}};
            remaining_r[c]   <= 32'd0;
            outstanding_r[c] <= {CW{1'b0}};
            count_r[c]       <= {CW{1'b0}};
            rd_ptr_r[c]      <= {PW{1'b0}};
            wr_ptr_r[c]      <= {PW{1'b0}};
         end
         rr_r       <= {TAG_W{1'b0}};
         err_r      <= 1'b0;
         req_ld_r   <= 1'b0;
         req_addr_r <= {ADDR_W{1'b0}};
         req_tag_r  <= {TAG_W{1'b0}};
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (arm_s[c]) begin
               addr_r[c]      <= start_addr;
               remaining_r[c] <= start_len;
            end else if (issue_s[c]) begin
               addr_r[c]      <= addr_r[c] + STRIDE;
               remaining_r[c] <= remaining_r[c] - 32'd1;
            end
            outstanding_r[c] <= outstanding_r[c] + CW'(issue_s[c]) - CW'(hit_s[c]);
            count_r[c]       <= count_r[c] + CW'(hit_s[c]) - CW'(pop_ok_s[c]);
            if (hit_s[c])    wr_ptr_r[c] <= wr_ptr_r[c] + PW'(1);
            if (pop_ok_s[c]) rd_ptr_r[c] <= rd_ptr_r[c] + PW'(1);
         end
         err_r    <= err_r || (rearm_s != {CHANNELS{1'b0}}) || rsp_err_s;
         req_ld_r <= issue_any_s;
         if (issue_any_s) begin
            req_addr_r <= addr_r[grant_s];
            req_tag_r  <= grant_s;
            rr_r       <= rr_next_s;
         end
      end
   end

   // FIFO storage; pointers carry the reset, so the data array needs none.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (hit_s[c]) fifo_r[c][wr_ptr_r[c]] <= rsp_mem_q;
      end
   end

   assign busy          = busy_s;
   assign err           = err_r;
   assign req_mem_ld    = req_ld_r;
   assign req_mem_addr  = req_addr_r;
   assign req_mem_tag   = req_tag_r;
   assign rsp_mem_stall = 1'b0;
endmodule

// File: tb/tb_mem_stream_fetcher.sv
// Directed bench for mem_stream_fetcher: one-cycle memory model, request/pop logs,
// hand-computed expected addresses and data (mem[a/8] = {16'hC0DE, a>>3}).
module tb_mem_stream_fetcher;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   start_ch = 2'd0;
   logic [47:0]  start_addr = 48'd0;
   logic [31:0]  start_len = 32'd0;
   logic [3:0]   busy;
   logic         err;
   logic         req_mem_ld;
   logic [47:0]  req_mem_addr;
   logic [1:0]   req_mem_tag;
   logic         req_mem_stall = 1'b0;
   logic         rsp_mem_push = 1'b0;
   logic [1:0]   rsp_mem_tag = 2'd0;
   logic [63:0]  rsp_mem_q = 64'd0;
   logic         rsp_mem_stall;
   logic [3:0]   valid;
   logic [255:0] q;
   logic [3:0]   pop = 4'd0;

   logic         inj_push = 1'b0;
   logic [1:0]   inj_tag = 2'd0;
   logic [63:0]  inj_q = 64'd0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [47:0] req_addr_q[$];
   logic [1:0]  req_tag_q[$];
   int          req_cyc_q[$];
   logic [65:0] got_q[$];

   logic        m_ld, m_rst, m_inj;
   logic [47:0] m_addr;
   logic [1:0]  m_tag, m_inj_tag;
   logic [63:0] m_inj_q;

   mem_stream_fetcher dut (
      .clk(clk), .rst(rst), .start(start), .start_ch(start_ch),
      .start_addr(start_addr), .start_len(start_len), .busy(busy), .err(err),
      .req_mem_ld(req_mem_ld), .req_mem_addr(req_mem_addr), .req_mem_tag(req_mem_tag),
      .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag),
      .rsp_mem_q(rsp_mem_q), .rsp_mem_stall(rsp_mem_stall), .valid(valid), .q(q), .pop(pop)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mem_word(input logic [47:0] a);
      return {16'hC0DE, 3'b000, a[47:3]};
   endfunction

   // Memory model and monitors: log requests and pops at the edge, answer one cycle later.
   always @(posedge clk) begin
      cyc++;
      m_ld = req_mem_ld;  m_addr = req_mem_addr;  m_tag = req_mem_tag;  m_rst = rst;
      m_inj = inj_push;   m_inj_tag = inj_tag;     m_inj_q = inj_q;
      if (m_ld && !m_rst) begin
         req_addr_q.push_back(m_addr);
         req_tag_q.push_back(m_tag);
         req_cyc_q.push_back(cyc);
      end
      for (int c = 0; c < 4; c++) begin
         if (pop[c] && valid[c] && !m_rst) got_q.push_back({2'(c), q[c*64 +: 64]});
      end
      #1;
      rsp_mem_push = (m_ld && !m_rst) || m_inj;
      rsp_mem_tag  = m_inj ? m_inj_tag : m_tag;
      rsp_mem_q    = m_inj ? m_inj_q : mem_word(m_addr);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      req_addr_q.delete();
      req_tag_q.delete();
      req_cyc_q.delete();
      got_q.delete();
   endtask

   task automatic arm(input logic [1:0] ch, input logic [47:0] a, input logic [31:0] len);
      start = 1'b1;  start_ch = ch;  start_addr = a;  start_len = len;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((busy != 4'd0 || valid != 4'd0) && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, 64'(n >= budget), 64'd0);
   endtask

   function automatic logic [63:0] req_a(input int i);
      if (i < req_addr_q.size()) return 64'(req_addr_q[i]);
      return {64{1'b1}};
   endfunction

   function automatic logic [63:0] req_t(input int i);
      if (i < req_tag_q.size()) return 64'(req_tag_q[i]);
      return {64{1'b1}};
   endfunction

   function automatic logic [63:0] got_d(input int i);
      if (i < got_q.size()) return got_q[i][63:0];
      return {64{1'b1}};
   endfunction

   function automatic logic [63:0] got_c(input int i);
      if (i < got_q.size()) return 64'(got_q[i][65:64]);
      return {64{1'b1}};
   endfunction

   initial begin
      int n, stall_hits, ch;
      int k[4];
      repeat (3) tick();
      check_eq("rst_req_ld", 64'(req_mem_ld), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_valid", 64'(valid), 64'd0);
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_q_or", 64'(|q), 64'd0);
      check_eq("rst_rsp_stall", 64'(rsp_mem_stall), 64'd0);
      rst = 1'b0;
      tick();
      clear_logs();

      // 1: single stream with pop held, including first-request latency
      pop = 4'hF;
      arm(2'd0, 48'h100, 32'd3);
      check_eq("t1_busy_rise", 64'(busy), 64'h1);
      check_eq("t1_no_req_yet", 64'(req_mem_ld), 64'd0);
      tick();
      check_eq("t1_first_ld", 64'(req_mem_ld), 64'd1);
      check_eq("t1_first_addr", 64'(req_mem_addr), 64'h100);
      wait_idle("t1_timeout", 30);
      check_eq("t1_nreq", 64'(req_addr_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         check_eq("t1_addr", req_a(i), 64'h100 + 64'(8 * i));
         check_eq("t1_tag", req_t(i), 64'd0);
         check_eq("t1_data", got_d(i), 64'hC0DE_0000_0000_0020 + 64'(i));
      end
      if (req_cyc_q.size() == 3) begin
         check_eq("t1_back2back_a", 64'(req_cyc_q[1] - req_cyc_q[0]), 64'd1);
         check_eq("t1_back2back_b", 64'(req_cyc_q[2] - req_cyc_q[1]), 64'd1);
      end
      check_eq("t1_ngot", 64'(got_q.size()), 64'd3);
      check_eq("t1_err", 64'(err), 64'd0);
      clear_logs();

      // 2: credit limit, then one pop releases exactly one more request
      pop = 4'h0;
      arm(2'd1, 48'h200, 32'd20);
      repeat (30) tick();
      check_eq("t2_nreq", 64'(req_addr_q.size()), 64'd8);
      check_eq("t2_last_addr", req_a(7), 64'h238);
      check_eq("t2_ld_idle", 64'(req_mem_ld), 64'd0);
      check_eq("t2_valid", 64'(valid), 64'h2);
      check_eq("t2_head", q[127:64], 64'hC0DE_0000_0000_0040);
      check_eq("t2_busy", 64'(busy), 64'h2);
      pop = 4'h2;
      tick();
      pop = 4'h0;
      repeat (10) tick();
      check_eq("t2_nreq_after_pop", 64'(req_addr_q.size()), 64'd9);
      check_eq("t2_extra_addr", req_a(8), 64'h240);
      check_eq("t2_popped_ch", got_c(0), 64'd1);
      check_eq("t2_popped_data", got_d(0), 64'hC0DE_0000_0000_0040);
      pop = 4'hF;
      wait_idle("t2_drain_timeout", 100);
      check_eq("t2_total_req", 64'(req_addr_q.size()), 64'd20);
      clear_logs();

      // 3: round robin across four channels
      for (int c = 0; c < 4; c++) arm(2'(c), 48'h1000 * 48'(c + 1), 32'd4);
      wait_idle("t3_timeout", 100);
      check_eq("t3_nreq", 64'(req_addr_q.size()), 64'd16);
      for (int i = 0; i < 16; i++) begin
         check_eq("t3_tag", req_t(i), 64'(i % 4));
         check_eq("t3_addr", req_a(i), 64'h1000 * 64'(i % 4 + 1) + 64'(8 * (i / 4)));
      end
      check_eq("t3_ngot", 64'(got_q.size()), 64'd16);
      for (int c = 0; c < 4; c++) k[c] = 0;
      for (int i = 0; i < 16; i++) begin
         ch = int'(got_c(i) & 64'h3);
         check_eq("t3_data", got_d(i), 64'hC0DE_0000_0000_0000 + 64'h200 * 64'(ch + 1) + 64'(k[ch]));
         k[ch]++;
      end
      clear_logs();

      // 4: request stall after the third request
      arm(2'd2, 48'h5000, 32'd10);
      n = 0;
      for (int b = 0; b < 20 && n < 3; b++) begin
         tick();
         if (req_mem_ld) n++;
      end
      check_eq("t4_three_seen", 64'(n), 64'd3);
      req_mem_stall = 1'b1;
      stall_hits = 0;
      repeat (5) begin
         tick();
         if (req_mem_ld) stall_hits++;
      end
      req_mem_stall = 1'b0;
      check_eq("t4_stall_quiet", 64'(stall_hits), 64'd0);
      wait_idle("t4_timeout", 60);
      check_eq("t4_nreq", 64'(req_addr_q.size()), 64'd10);
      for (int i = 0; i < 10; i++) begin
         check_eq("t4_addr", req_a(i), 64'h5000 + 64'(8 * i));
         check_eq("t4_tag", req_t(i), 64'd2);
      end
      clear_logs();

      // 5: re-arm while busy, then stray response after reset
      arm(2'd0, 48'h6000, 32'd6);
      tick();
      check_eq("t5_err_before", 64'(err), 64'd0);
      arm(2'd0, 48'h9000, 32'd2);
      check_eq("t5_err_rearm", 64'(err), 64'd1);
      wait_idle("t5_timeout", 40);
      check_eq("t5_nreq", 64'(req_addr_q.size()), 64'd6);
      for (int i = 0; i < 6; i++) check_eq("t5_addr", req_a(i), 64'h6000 + 64'(8 * i));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("t5_err_cleared", 64'(err), 64'd0);
      inj_push = 1'b1;  inj_tag = 2'd3;  inj_q = 64'h1234_5678_9ABC_DEF0;
      tick();
      inj_push = 1'b0;
      tick();
      check_eq("t5_err_stray", 64'(err), 64'd1);
      check_eq("t5_stray_dropped", 64'(valid), 64'd0);
      clear_logs();

      // 6: reset mid-stream, then address wrap
      pop = 4'h0;
      arm(2'd3, 48'h7000, 32'd10);
      repeat (4) tick();
      check_eq("t6_valid_pre", 64'(valid[3]), 64'd1);
      rst = 1'b1;
      tick();
      check_eq("t6_rst_ld", 64'(req_mem_ld), 64'd0);
      check_eq("t6_rst_addr", 64'(req_mem_addr), 64'd0);
      check_eq("t6_rst_tag", 64'(req_mem_tag), 64'd0);
      check_eq("t6_rst_busy", 64'(busy), 64'd0);
      check_eq("t6_rst_valid", 64'(valid), 64'd0);
      check_eq("t6_rst_err", 64'(err), 64'd0);
      check_eq("t6_rst_q_or", 64'(|q), 64'd0);
      check_eq("t6_rst_rsp_stall", 64'(rsp_mem_stall), 64'd0);
      rst = 1'b0;
      repeat (2) tick();
      check_eq("t6_no_stale", 64'(err), 64'd0);
      clear_logs();
      pop = 4'hF;
      arm(2'd0, 48'hFFFF_FFFF_FFF8, 32'd2);
      wait_idle("t6_timeout", 30);
      check_eq("t6_nreq", 64'(req_addr_q.size()), 64'd2);
      check_eq("t6_addr0", req_a(0), 64'hFFFF_FFFF_FFF8);
      check_eq("t6_addr1", req_a(1), 64'd0);
      check_eq("t6_data0", got_d(0), 64'hC0DE_1FFF_FFFF_FFFF);
      check_eq("t6_data1", got_d(1), 64'hC0DE_0000_0000_0000);
      check_eq("t6_err", 64'(err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected test end");
      $fatal(1, "watchdog");
   end
endmodule
